clk_divider_prog: RTL
=====================

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 8, the width of the divisor and counter.
REQ-002 SHALL have parameter DIV_INIT, default 5, the divisor after reset; legal range 2..2^DIV_W-1.
REQ-003 SHALL have port clk_in, input, 1 bit: the single source clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: run request for the divided clock.
REQ-006 SHALL have port div_val, input, DIV_W bits: new divisor value.
REQ-007 SHALL have port div_load, input, 1 bit: single-cycle strobe that captures div_val.
REQ-008 SHALL have port clk_out, output, 1 bit: the divided clock.
REQ-009 SHALL have port div_ack, output, 1 bit: one-cycle pulse when a new divisor takes effect.
REQ-010 SHALL have port div_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-011 SHALL divide clk_in by any integer N in 2..2^DIV_W-1, odd or even, with N taken from the active divisor register div_q.
REQ-012 SHALL run counter cnt over 0..N-1 on posedge clk_in and wrap from N-1 to 0; the cycle with cnt==N-1 is the terminal count (TC).
REQ-013 SHALL drive posedge phase clk_p high for ceil(N/2) clk_in periods starting at cnt==0, then low for floor(N/2) periods.
REQ-014 SHALL give 50% duty for even N: high for N/2 periods, low for N/2 periods.
REQ-015 SHALL use a two-state FSM, IDLE and RUN: IDLE -> RUN on the first posedge with en=1, with cnt=0 and clk_out rising on that edge; RUN -> IDLE only at TC with en=0.
REQ-016 SHALL, when en falls mid-period, complete the current period, then park clk_out low with cnt=0, so that no runt pulse is produced.
REQ-017 SHALL register a load of div_val>=2 into a pending register; in RUN it takes effect at the next TC boundary, and in IDLE it takes effect on the next posedge.
REQ-018 SHALL apply a div_load that coincides with TC at that same boundary.
REQ-019 SHALL, when a second load arrives before the pending value is applied, overwrite the pending value (last write wins) and acknowledge only once.
REQ-020 SHALL pulse div_ack for one cycle, coincident with the first cnt==0 cycle that uses the new divisor, or the cycle after the apply edge when in IDLE.
REQ-021 SHALL, on a load with div_val<2, leave both the pending and active divisors unchanged and pulse div_err one cycle after the div_load.
REQ-022 SHALL change clk_out only on clock edges, never combinationally from div_val, en or div_load.

Reset
REQ-023 SHALL, while rst is asserted, hold cnt=0, FSM=IDLE, div_q=DIV_INIT, pending empty, clk_p=0, clk_n=0, and clk_out, div_ack and div_err at 0.
REQ-024 SHALL abort the period when rst is asserted mid-period, drive clk_out 0 immediately (asynchronously), and resume from IDLE after rst is released.

Configuration
REQ-025 SHALL provide macro CLKDIV_DUTY50_EN.
REQ-026 SHALL, when CLKDIV_DUTY50_EN is defined and N is odd, have a negedge flop clk_n retime clk_p, with clk_out = clk_p AND clk_n; clk_out is then high for N/2 clk_in periods (exactly 50% duty).
REQ-027 SHALL, when CLKDIV_DUTY50_EN is defined and N is even, set clk_out = clk_p.
REQ-028 SHALL, when CLKDIV_DUTY50_EN is undefined, contain no negedge logic and set clk_out = clk_p for all N, so odd N gives ceil(N/2)/floor(N/2) duty.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, RUN), the default DIV_W and the minimum-divisor constant (2) in shared package clk_div_pkg.
REQ-030 SHALL put the negedge retiming stage and the AND logic in sub-module clk_div_duty, which is instantiated only under CLKDIV_DUTY50_EN.

Verification
REQ-031 SHALL verify: reset release, en=1, N=5, macro defined -> clk_out period of 5 clk_in cycles, high time 2.5 cycles.
REQ-032 SHALL verify: same stimulus with the macro undefined -> high for 3 cycles, low for 2 cycles.
REQ-033 SHALL verify: N=4 running, div_val=7 loaded at cnt==1 -> current period completes at 4 cycles, then 7-cycle periods, with div_ack in the first cnt==0 cycle of the first 7-cycle period.
REQ-034 SHALL verify: div_load with div_val=1 -> div_err pulse one cycle later, and the period stays unchanged.
REQ-035 SHALL verify: N=6, en dropped at cnt==2 -> full 6-cycle period finishes, then clk_out stays 0; en reasserted -> clk_out rises on the next edge.
REQ-036 SHALL verify: rst asserted mid-high phase with N=9 -> clk_out 0 at once; after release, div_q=DIV_INIT (5).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIV_W_DEF = 8;
    localparam int DIV_MIN   = 2;

    // Length of the high phase of clk_p for divisor n: ceil(n/2).
    function automatic logic [31:0] ceil_half(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_duty.sv
// Odd-divisor duty correction: a negedge retime of clk_p ANDed with clk_p
// trims half a source period off the high phase. Used only with CLKDIV_DUTY50_EN.
module clk_div_duty (
    input  logic clk_in,
    input  logic rst,
    input  logic clk_p,
    input  logic odd,
    output logic clk_out
);

    logic clk_n_d;
    logic clk_n_q;

    assign clk_n_d = clk_p;

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_n_d;
        end
    end

    assign clk_out = odd ? (clk_p & clk_n_q) : clk_p;

endmodule

// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider (N = 2..2^DIV_W-1) with glitch-free
// divisor reload and clean stop. Define CLKDIV_DUTY50_EN for 50% duty on odd N.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV_INIT = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             div_ack,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_p_q, clk_p_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic load_ok;
    logic tc;
    logic boundary;

    assign load_ok  = div_load && (div_val >= DIV_FLOOR);
    assign tc       = (state_q == RUN) && (cnt_q == div_q - DIV_W'(1));
    assign boundary = (state_q == IDLE) || tc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        err_d      = div_load && !load_ok;

        // A load landing exactly on TC bypasses the pending register.
        if (tc && load_ok) begin
            div_d      = div_val;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end else begin
            if (boundary && pend_vld_q) begin
                div_d      = pend_q;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
            if (load_ok) begin
                pend_d     = div_val;
                pend_vld_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tc) begin
                    cnt_d = '0;
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered so clk_p lines up with the cycle whose cnt it describes.
        clk_p_d = (state_d == RUN) && (32'(cnt_d) < ceil_half(32'(div_d)));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_p_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_p_q    <= clk_p_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;

`ifdef CLKDIV_DUTY50_EN
    clk_div_duty u_duty (
        .clk_in  (clk_in),
        .rst     (rst),
        .clk_p   (clk_p_q),
        .odd     (div_q[0]),
        .clk_out (clk_out)
    );
`else
    assign clk_out = clk_p_q;
`endif

endmodule
